// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one EXU request, issues a word-aligned bus access with
// byte strobes, and returns sign/zero-extended load data (or a misalign flag) to write-back.
module lsu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic [2:0]       in_mem_op,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_misalign,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             misalign_q, misalign_d;

  logic             illegal_in;
  logic [1:0]       off;
  logic [WIDTH-1:0] rsp_shifted;
  logic [WIDTH-1:0] load_data;

  assign off = addr_q[1:0];

  always_comb begin
    illegal_in = 1'b0;
    case (in_mem_op[1:0])
      2'b01:   illegal_in = in_addr[0];
      2'b10:   illegal_in = |in_addr[1:0];
      2'b11:   illegal_in = 1'b1;
      default: illegal_in = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per size; mem_op[2] selects unsigned.
  assign rsp_shifted = mem_rsp_rdata >> {off, 3'b000};

  always_comb begin
    case (op_q[1:0])
      2'b00:   load_data = {{(WIDTH-8){~op_q[2] & rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'b01:   load_data = {{(WIDTH-16){~op_q[2] & rsp_shifted[15]}}, rsp_shifted[15:0]};
      default: load_data = rsp_shifted;
    endcase
  end

  always_comb begin
    mem_req_wstrb = 4'b0000;
    if (we_q) begin
      case (op_q[1:0])
        2'b00:   mem_req_wstrb = 4'b0001 << off;
        2'b01:   mem_req_wstrb = 4'b0011 << off;
        2'b10:   mem_req_wstrb = 4'b1111;
        default: mem_req_wstrb = 4'b0000;
      endcase
    end
  end

  assign mem_req_valid = (state_q == StReq);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_req_wdata = we_q ? (wdata_q << {off, 3'b000}) : '0;

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign out_rdata    = rdata_q;
  assign out_misalign = misalign_q;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          we_d       = in_we;
          op_d       = in_mem_op;
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          rdata_d    = '0;
          misalign_d = illegal_in;
          state_d    = illegal_in ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : load_data;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          rdata_d    = '0;
          misalign_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      op_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
